// File: rtl/axi_mem_pkg.sv
// Shared AXI constants, FSM state types and sizing helper for the memory responder.
package axi_mem_pkg;

   localparam logic [1:0] INCR   = 2'b01;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } w_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_DATA
   } r_state_t;

   // Number of bytes carried by one data beat of the given port width.
   function automatic int Bytes_in_Word(input int port_size);
      return port_size / 8;
   endfunction

endpackage

// File: rtl/axi_mem_sdp_ram.sv
// Simple dual-port RAM: byte-enable write port, registered read port with read enable.
// A read and a write to the same word in the same cycle returns the old contents.
module axi_mem_sdp_ram #(
   parameter int DATA_W = 128,
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
) (
   input  logic                  aclk,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wstrb,
   input  logic                  re,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [DATA_W-1:0]     rdata
);

   localparam int NB = DATA_W / 8;

   logic [DATA_W-1:0] mem [DEPTH];

   // Byte-masked write of the addressed word.
   // NOTE: sequential state uses <= so every block sees pre-edge values; the array
   // has no reset on purpose so it maps to RAM and keeps its contents across areset.
   always_ff @(posedge aclk) begin
      if (we) begin
         for (int b = 0; b < NB; b++) begin
            if (wstrb[b]) begin
               mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   // Registered read; output holds while re is low.
   always_ff @(posedge aclk) begin
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 INCR-burst responder backed by an internal byte-enable memory.
// Independent write and read FSMs, one outstanding burst each; init_calib
// gates command acceptance after a fixed delay from reset release.
module axi_mem_responder
   import axi_mem_pkg::*;
#(
   parameter int          ID_Width      = 4,
   parameter int          MIG_Port_Size = 128,
   parameter logic [31:0] Base_Address  = 32'h0,
   parameter int          Memory_Size   = 1024,
   parameter int          Read_Latency  = 2,
   parameter int          Calib_Cycles  = 16
) (
   input  logic                       aclk,
   input  logic                       areset,
   output logic                       init_calib,
   input  logic [ID_Width-1:0]        AWID,
   input  logic [31:0]                AWADDR,
   input  logic [7:0]                 AWLEN,
   input  logic [2:0]                 AWSIZE,
   input  logic [1:0]                 AWBURST,
   input  logic                       AWVALID,
   output logic                       AWREADY,
   input  logic [MIG_Port_Size-1:0]   WDATA,
   input  logic [MIG_Port_Size/8-1:0] WSTRB,
   input  logic                       WLAST,
   input  logic                       WVALID,
   output logic                       WREADY,
   output logic [ID_Width-1:0]        BID,
   output logic [1:0]                 BRESP,
   output logic                       BVALID,
   input  logic                       BREADY,
   input  logic [ID_Width-1:0]        ARID,
   input  logic [31:0]                ARADDR,
   input  logic [7:0]                 ARLEN,
   input  logic [2:0]                 ARSIZE,
   input  logic [1:0]                 ARBURST,
   input  logic                       ARVALID,
   output logic                       ARREADY,
   output logic [ID_Width-1:0]        RID,
   output logic [MIG_Port_Size-1:0]   RDATA,
   output logic [1:0]                 RRESP,
   output logic                       RLAST,
   output logic                       RVALID,
   input  logic                       RREADY
);

   localparam int          BYTES      = Bytes_in_Word(MIG_Port_Size);
   localparam int          BSHIFT     = $clog2(BYTES);
   localparam int          ADDR_W     = (Memory_Size > 1) ? $clog2(Memory_Size) : 1;
   localparam int          LAT_W      = $clog2(Read_Latency + 1);
   localparam logic [63:0] BYTES64    = 64'(BYTES);
   localparam logic [63:0] MEM_END    = {32'd0, Base_Address} + 64'(Memory_Size) * BYTES64;
   localparam logic [2:0]  SIZE_OK    = 3'(BSHIFT);
   localparam logic [31:0] ALIGN_MASK = 32'(BYTES - 1);
   localparam logic [31:0] CAL_TARGET = 32'(Calib_Cycles);

   // Range errors take precedence over format errors.
   function automatic logic [1:0] cmd_check(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
      logic [63:0] end_addr;
      logic [1:0]  resp;
      end_addr = {32'd0, addr} + ({56'd0, len} + 64'd1) * BYTES64;
      if (addr < Base_Address || end_addr > MEM_END) begin
         resp = DECERR;
      end else if (burst != INCR || size != SIZE_OK || (addr & ALIGN_MASK) != 32'd0) begin
         resp = SLVERR;
      end else begin
         resp = OKAY;
      end
      return resp;
   endfunction

   function automatic logic [ADDR_W-1:0] word_index(input logic [31:0] addr);
      return ADDR_W'((addr - Base_Address) >> BSHIFT);
   endfunction

   logic [31:0]         cal_cnt;

   w_state_t            w_state, w_state_nxt;
   logic [1:0]          w_cmd_resp;
   logic                w_wlast_err;
   logic [7:0]          w_len;
   logic [8:0]          w_beat;
   logic [ADDR_W-1:0]   w_idx;
   logic                aw_hs, w_hs, w_final, ram_we;

   r_state_t            r_state, r_state_nxt;
   logic [1:0]          r_resp;
   logic [7:0]          r_len;
   logic [8:0]          r_beat;
   logic [ADDR_W-1:0]   r_idx;
   logic [LAT_W-1:0]    r_lat;
   logic                ar_hs, r_hs, r_last, ram_re;
   logic [MIG_Port_Size-1:0] ram_q;

   // Calibration delay counted from reset release; init_calib then holds.
   always_ff @(posedge aclk) begin
      if (areset) begin
         cal_cnt    <= '0;
         init_calib <= 1'b0;
      end else if (!init_calib) begin
         cal_cnt <= cal_cnt + 32'd1;
         if (cal_cnt + 32'd1 >= CAL_TARGET) begin
            init_calib <= 1'b1;
         end
      end
   end

   // ---------------- write channel ----------------
   assign aw_hs   = AWVALID && AWREADY;
   assign w_hs    = WVALID && WREADY;
   assign w_final = (w_beat == {1'b0, w_len});
   assign ram_we  = w_hs && (w_cmd_resp == OKAY);
   assign BRESP   = (w_cmd_resp != OKAY) ? w_cmd_resp : (w_wlast_err ? SLVERR : OKAY);

   // Write FSM state register.
   always_ff @(posedge aclk) begin
      if (areset) w_state <= W_IDLE;
      else        w_state <= w_state_nxt;
   end

   // Write FSM next state and handshake outputs.
   // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_nxt = w_state;
      AWREADY     = 1'b0;
      WREADY      = 1'b0;
      BVALID      = 1'b0;
      case (w_state)
         W_IDLE: begin
            AWREADY = init_calib;
            if (AWVALID && init_calib) w_state_nxt = W_DATA;
         end
         W_DATA: begin
            WREADY = 1'b1;
            if (WVALID && w_final) w_state_nxt = W_RESP;
         end
         W_RESP: begin
            BVALID = 1'b1;
            if (BREADY) w_state_nxt = W_IDLE;
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   // Write burst bookkeeping: command capture, beat count, WLAST placement check.
   always_ff @(posedge aclk) begin
      if (areset) begin
         BID         <= '0;
         w_cmd_resp  <= OKAY;
         w_wlast_err <= 1'b0;
         w_len       <= '0;
         w_beat      <= '0;
         w_idx       <= '0;
      end else begin
         if (aw_hs) begin
            BID         <= AWID;
            w_cmd_resp  <= cmd_check(AWADDR, AWLEN, AWSIZE, AWBURST);
            w_wlast_err <= 1'b0;
            w_len       <= AWLEN;
            w_beat      <= '0;
            w_idx       <= word_index(AWADDR);
         end
         if (w_hs) begin
            w_beat <= w_beat + 9'd1;
            w_idx  <= w_idx + ADDR_W'(1);
            if (WLAST != w_final) w_wlast_err <= 1'b1;
         end
      end
   end

   // ---------------- read channel ----------------
   assign ar_hs  = ARVALID && ARREADY;
   assign r_hs   = RVALID && RREADY;
   assign r_last = (r_state == R_DATA) && (r_beat == {1'b0, r_len});
   assign RLAST  = r_last;
   assign RRESP  = r_resp;
   assign RDATA  = (r_state == R_DATA && r_resp == OKAY) ? ram_q : '0;

   // Read FSM state register.
   always_ff @(posedge aclk) begin
      if (areset) r_state <= R_IDLE;
      else        r_state <= r_state_nxt;
   end

   // Read FSM next state, handshake outputs and RAM fetch: the first word is
   // fetched as the latency expires, each further word on a beat handshake.
   always_comb begin
      r_state_nxt = r_state;
      ARREADY     = 1'b0;
      RVALID      = 1'b0;
      ram_re      = 1'b0;
      case (r_state)
         R_IDLE: begin
            ARREADY = init_calib;
            if (ARVALID && init_calib) r_state_nxt = R_WAIT;
         end
         R_WAIT: begin
            if (r_lat == '0) begin
               r_state_nxt = R_DATA;
               ram_re      = (r_resp == OKAY);
            end
         end
         R_DATA: begin
            RVALID = 1'b1;
            if (RREADY) begin
               if (r_last) r_state_nxt = R_IDLE;
               else        ram_re      = (r_resp == OKAY);
            end
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   // Read burst bookkeeping: command capture, latency countdown, fetch pointer, beat count.
   always_ff @(posedge aclk) begin
      if (areset) begin
         RID    <= '0;
         r_resp <= OKAY;
         r_len  <= '0;
         r_beat <= '0;
         r_idx  <= '0;
         r_lat  <= '0;
      end else begin
         if (ar_hs) begin
            RID    <= ARID;
            r_resp <= cmd_check(ARADDR, ARLEN, ARSIZE, ARBURST);
            r_len  <= ARLEN;
            r_beat <= '0;
            r_idx  <= word_index(ARADDR);
            r_lat  <= LAT_W'(Read_Latency - 1);
         end else if (r_state == R_WAIT && r_lat != '0) begin
            r_lat <= r_lat - LAT_W'(1);
         end
         if (ram_re) r_idx  <= r_idx + ADDR_W'(1);
         if (r_hs)   r_beat <= r_beat + 9'd1;
      end
   end

   axi_mem_sdp_ram #(
      .DATA_W (MIG_Port_Size),
      .DEPTH  (Memory_Size),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .aclk  (aclk),
      .we    (ram_we),
      .waddr (w_idx),
      .wdata (WDATA),
      .wstrb (WSTRB),
      .re    (ram_re),
      .raddr (r_idx),
      .rdata (ram_q)
   );

endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
AXI4 slave (responder) for MIG-port-style bursts: accepts INCR write and read bursts from the FIFO memory controller and serves them from an internal byte-enable memory array. Provides init_calib after a programmable calibration delay. Used as the simulation/bring-up stand-in for the MIG user port and as an on-chip buffer in small configurations. Write and read channels run independently, one outstanding burst per direction.

Parameters:
ID_Width, 4, width of AWID/BID/ARID/RID
MIG_Port_Size, 128, data width in bits (power of 2, ≥8)
Base_Address, 0, byte address of word 0
Memory_Size, 1024, depth in words
Read_Latency, 2, cycles from AR handshake to first RVALID (≥1)
Calib_Cycles, 16, cycles after reset release before init_calib=1

Ports:
aclk  in  1  clock
areset  in  1  synchronous reset, active-high
init_calib  out  1  calibration done
AWID  in  ID_Width  write ID
AWADDR  in  32  write byte address
AWLEN  in  8  beats-1
AWSIZE  in  3  beat size
AWBURST  in  2  burst type
AWVALID/AWREADY  in/out  1  AW handshake
WDATA  in  MIG_Port_Size  write data
WSTRB  in  MIG_Port_Size/8  byte enables
WLAST  in  1  last beat
WVALID/WREADY  in/out  1  W handshake
BID  out  ID_Width  = captured AWID
BRESP  out  2  write response
BVALID/BREADY  out/in  1  B handshake
ARID, ARADDR, ARLEN, ARSIZE, ARBURST  in  as AW  read command
ARVALID/ARREADY  in/out  1  AR handshake
RID  out  ID_Width  = captured ARID
RDATA  out  MIG_Port_Size  read data
RRESP  out  2  read response
RLAST  out  1  last beat
RVALID/RREADY  out/in  1  R handshake
(REGION/LOCK/CACHE/PROT/QOS not present; ignored.)

Behaviour:
- Reset: all FSMs idle; every ready/valid output 0, init_calib 0, BRESP/RRESP 0, RLAST 0, BID/RID/RDATA 0. Memory contents preserved. Reset mid-burst abandons burst, no B/R issued.
- Calibration: counter starts at reset release; init_calib=1 exactly Calib_Cycles cycles later, then holds. AWREADY/ARREADY held 0 until init_calib=1.
- Command check (both directions): Bytes=MIG_Port_Size/8. OKAY(00) if burst=INCR(01), size=log2(Bytes), addr aligned, and Base_Address ≤ addr and addr+(LEN+1)*Bytes ≤ Base_Address+Memory_Size*Bytes. Out-of-range → DECERR(11); other violations → SLVERR(10). Errored bursts still complete the full handshake beat count; no memory writes; read data 0.
- Write FSM: W_IDLE (AWREADY=1) -AW hs→ W_DATA (WREADY=1; one cycle after AW accept; WVALID before AW accept simply waits) -beat count=AWLEN+1 hs→ W_RESP (BVALID=1, held until BREADY) -B hs→ W_IDLE. Each beat writes bytes where WSTRB=1 at word index, index increments per beat. WLAST not on final beat, or asserted early → BRESP=SLVERR (early WLAST does not end burst; beats counted by AWLEN).
- Read FSM: R_IDLE (ARREADY=1) -AR hs→ R_WAIT (latency counter Read_Latency-1) → R_DATA (RVALID=1; RDATA/RLAST/RRESP stable until RREADY) -hs with RLAST→ R_IDLE. Next word fetched on each handshake so back-to-back beats sustain 1 beat/cycle. RLAST=1 on beat ARLEN+1 only.
- Simultaneous write and read to same word in same cycle: read returns old contents.
- Widths: internal beat counters 9 bits; word index = (addr-Base_Address)/Bytes, computed in 32-bit arithmetic.

Decomposition:
- Package axi_mem_pkg: burst/resp constants (INCR, OKAY, SLVERR, DECERR), write-state and read-state enums, Bytes_in_Word function.
- Sub-module axi_mem_sdp_ram: simple dual-port RAM, byte-enable write port, registered read port with read enable.

Test Plan:
- Reset, Calib_Cycles=16 → init_calib rises on cycle 16 after areset deasserts; ARVALID held high earlier sees ARREADY=0 until then.
- AW addr 0x0, LEN=3, WDATA 1..4, WSTRB all ones → BRESP=00; AR addr 0x0 LEN=3 → RDATA 1,2,3,4, RLAST on 4th, first RVALID 2 cycles after AR hs.
- Read LEN=63 with RREADY toggling 1/0 each cycle → 64 beats in order, no data loss, RDATA stable while stalled.
- AW addr=Base+(Memory_Size-2)*16, LEN=3 → DECERR, 4 W beats accepted, memory unchanged (readback verifies).
- WLAST on beat 2 of LEN=3 burst → burst runs 4 beats, BRESP=SLVERR; WSTRB=0x0001 writes only byte 0.
- Write burst and read burst to same region concurrently, then areset asserted mid-read → RVALID drops next cycle, FSMs idle, written data intact after recalibration.
